// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream multiplexer/arbiter slice.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n items, never below one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping to 0.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx
);

  logic found;

  // Pass one scans ptr..NCH-1, pass two wraps through 0..ptr-1
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (!found && req[c] && (c >= 32'(ptr))) begin
        grant[c]  = 1'b1;
        grant_idx = SELW'(c);
        found     = 1'b1;
      end
    end
    for (int unsigned c = 0; c < NCH; c++) begin
      if (!found && req[c] && (c < 32'(ptr))) begin
        grant[c]  = 1'b1;
        grant_idx = SELW'(c);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with fixed-select or round-robin grant and a
// registered output stage tagged with the source channel index.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = clog2_min1(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  logic [NCH-1:0]   req;
  logic [NCH-1:0]   fix_grant;
  logic [NCH-1:0]   rr_grant;
  logic [SELW-1:0]  rr_idx;
  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  grant_idx;
  logic             any_grant;
  logic             load_c;
  logic [WIDTH-1:0] sel_data;
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_next;

  assign req = in_valid & ch_en;

  // Fixed decode; an out-of-range sel matches no channel
  always_comb begin
    fix_grant = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      fix_grant[i] = (32'(sel) == i) && in_valid[i] && ch_en[i];
    end
  end

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  assign grant     = (mode == MODE_RR) ? rr_grant : fix_grant;
  assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
  assign any_grant = |grant;
  assign load_c    = !out_valid || out_ready;
  assign in_ready  = load_c ? grant : '0;

  // Grant is one-hot, so the loop reduces to an indexed part-select of the winner
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign ptr_next = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if ((mode == MODE_RR) && load_c && any_grant) begin
      ptr <= ptr_next;
    end
  end

  // Output register: a held word only moves when downstream accepts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load_c) begin
      if (any_grant) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
